// File: rtl/mlm_ser_if.sv
// Codeword handshake between the Hamming encoder and the serializer.
// Bit 0 of in_data is the leftmost codeword bit and is transmitted first.
interface mlm_ser_if #(
  parameter int W = 21
);
  logic         in_valid;
  logic         in_ready;
  logic [0:W-1] in_data;

  modport master (output in_valid, output in_data, input  in_ready);
  modport slave  (input  in_valid, input  in_data, output in_ready);
endinterface

// File: rtl/mlm_ser.sv
// Codeword serializer: a one-word holding register feeds a shifter that emits
// one bit per clock, index 0 first, followed by GAP idle cycles per frame.
module mlm_ser #(
  parameter int W   = 21,
  parameter int GAP = 1,
  parameter int CW  = 16
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  mlm_ser_if.slave      s_in,
  output logic          o_sd,
  output logic          o_sv,
  output logic          o_sf,
  output logic          o_busy,
  output logic [CW-1:0] o_frm_cnt
);
  localparam int              KW     = $clog2(W);
  localparam logic [KW-1:0]   K_LAST = KW'(W - 1);
  localparam logic [3:0]      G_LAST = 4'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

  state_t        r_state;
  logic [0:W-1]  r_hold;
  logic          r_full;
  logic          r_rdy;
  logic [0:W-1]  r_sh;
  logic [KW-1:0] r_k;
  logic [3:0]    r_gc;
  logic          r_sd, r_sv, r_sf;
  logic [CW-1:0] r_cnt;

  logic w_acc, w_last, w_load;

  // in_ready is a plain register mirroring "holding register empty"
  assign w_acc  = s_in.in_valid & r_rdy;
  assign w_last = (r_state == S_SHIFT) && (r_k == K_LAST);
  assign w_load = r_full && ((r_state == S_IDLE) ||
                             (w_last && (GAP == 0)) ||
                             ((r_state == S_GAP) && (r_gc == G_LAST)));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_hold  <= '0;
      r_full  <= 1'b0;
      r_rdy   <= 1'b1;
      r_sh    <= '0;
      r_k     <= '0;
      r_gc    <= '0;
      r_sd    <= 1'b0;
      r_sv    <= 1'b0;
      r_sf    <= 1'b0;
      r_cnt   <= '0;
    end else begin
      // a same-edge accept wins: the old word leaves via the load below
      if (w_acc) begin
        r_hold <= s_in.in_data;
        r_full <= 1'b1;
        r_rdy  <= 1'b0;
      end else if (w_load) begin
        r_full <= 1'b0;
        r_rdy  <= 1'b1;
      end

      if (w_last) r_cnt <= r_cnt + 1'b1;

      if (w_load) begin
        r_state <= S_SHIFT;
        r_sh    <= r_hold;
        r_k     <= '0;
        r_gc    <= '0;
        r_sd    <= r_hold[0];
        r_sv    <= 1'b1;
        r_sf    <= 1'b1;
      end else begin
        unique case (r_state)
          S_SHIFT: begin
            if (w_last) begin
              r_sd    <= 1'b0;
              r_sv    <= 1'b0;
              r_sf    <= 1'b0;
              r_gc    <= '0;
              r_state <= (GAP > 0) ? S_GAP : S_IDLE;
            end else begin
              r_k  <= r_k + 1'b1;
              r_sd <= r_sh[1];
              r_sh <= {r_sh[1:W-1], 1'b0};
              r_sf <= 1'b0;
            end
          end
          S_GAP: begin
            if (r_gc == G_LAST) r_state <= S_IDLE;
            else                r_gc    <= r_gc + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign s_in.in_ready = r_rdy;
  assign o_sd          = r_sd;
  assign o_sv          = r_sv;
  assign o_sf          = r_sf;
  assign o_busy        = (r_state != S_IDLE) || r_full;
  assign o_frm_cnt     = r_cnt;
endmodule

// File: doc/mlm_ser.md
Name: mlm_ser

Overview:
- Serializer stage between the Hamming encoder (21-bit interlaced codeword, index 0 = leftmost) and the serial channel.
- Accepts codewords over a valid/ready handshake into a one-word holding register.
- Shifts each codeword out one bit per clock, index 0 first, with a frame-start strobe and a configurable idle gap between frames.
- Double-buffered: the next codeword can be accepted while the current one is shifting.

Parameters:
- W, 21: codeword width in bits.
- GAP, 1: idle cycles inserted after each frame. Legal range 0..15; 0 gives back-to-back frames.
- CW, 16: width of the frame counter.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset, asynchronous, active-low. Assertion (0) clears all state immediately; release is synchronous to clk.
- in_valid  input  1  in_data holds a codeword.
- in_ready  output  1  holding register empty; registered.
- in_data  input  [0:W-1]  codeword, bit 0 transmitted first.
- sd  output  1  serial data bit; registered.
- sv  output  1  sd valid, asserted for each of the W bit cycles of a frame.
- sf  output  1  frame start, asserted with bit 0 only.
- busy  output  1  high when state is not IDLE or the holding register is full.
- frm_cnt  output  [CW-1:0]  count of completed frames; wraps at 2^CW.

Behaviour:
- Reset values: sd=0, sv=0, sf=0, in_ready=1, busy=0, frm_cnt=0, holding register empty, state IDLE, bit counter 0, gap counter 0.
- Reset mid-frame aborts the frame. The held word is discarded and the frame is not counted.
- Accept: in_valid & in_ready at a posedge writes in_data into the holding register; in_ready falls on that edge.
- Load: the shifter loads from the holding register at a posedge when either:
  - state is IDLE, or
  - state is SHIFT on the last bit with GAP=0, or
  - state is GAP on its last gap cycle.
  On load the holding register empties.
- Accept and load in the same edge: the old held word goes to the shifter and the new word lands in the holding register; in_ready stays 0.
- in_ready is never combinationally dependent on in_valid.
- States:
  - IDLE: sv=0, sd=0, sf=0. Goes to SHIFT on load.
  - SHIFT: bit counter runs 0..W-1. Output is sd=shifter[k], sv=1, sf=(k==0).
    - At k=W-1: frm_cnt increments.
    - Next state is GAP if GAP>0; else SHIFT if the holding register is full (loading it); else IDLE.
  - GAP: sv=0, sd=0 for exactly GAP cycles. Then SHIFT if the holding register is full (loading it), else IDLE.
- Latency: word accepted at edge N in IDLE, loaded at edge N+1. Bit k is visible after edge N+1+k.
- Throughput: one frame per W+GAP cycles under continuous input.
- frm_cnt increments on the edge that retires bit W-1 and wraps from 2^CW-1 to 0.
- in_valid with in_ready=0: the word is not taken. The source must hold in_data and in_valid until accepted.

Test Plan:
- Reset, then a single word 21'h15A5A5 in IDLE → in_ready drops 1 cycle. sv high for 21 cycles, sf only on the first. sd sequence is 1,0,1,0,1,1,0,1,0,0,1,0,1,1,0,1,0,0,1,0,1. Then frm_cnt=1, busy=0 after the gap.
- Back-to-back 21'h000001 then 21'h100000 with in_valid held, GAP=1 → second word accepted during the first frame. Exactly 1 idle cycle between frames. sd=1 only on bit 20 of frame 1 and bit 0 of frame 2. frm_cnt=2.
- GAP=0, three words continuously presented → 63 consecutive sv cycles. sf at offsets 0, 21, 42. No bubble.
- rst asserted at bit 10 of frame 21'h1FFFFF with a word held → sd, sv, sf go to 0 immediately. in_ready=1, frm_cnt=0, and no frame resumes after release.
- in_valid pulsed while in_ready=0 → word ignored. Only held words are transmitted and the frame count matches accepted handshakes.
- CW=4, 17 frames → frm_cnt wraps to 0 after the 16th frame and reads 1 after the 17th.
